riscv_lsu: RTL and testbench

Multi-cycle load/store unit between the RV32I core's data-memory port and a word-addressed data bus with request/acknowledge handshake. Takes the core's ALU-computed address, store data, access width and direction, and drives byte-enabled bus beats. Splits misaligned halfword/word accesses into two beats, merges and extends load data, and stalls the core until the access completes.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 37 +++
 rtl/riscv_lsu.sv | 141 ++++++++++++++
 tb/tb_riscv_lsu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit: funct3 encodings,
// FSM state type and access-width decode.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  // Access size in bytes; only the low two funct3 bits encode width.
  function automatic logic [2:0] width_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   width_of = 3'd1;
      2'b01:   width_of = 3'd2;
      default: width_of = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
    if (is_store)
      funct3_legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    else
      funct3_legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                     (funct3 == LBU) || (funct3 == LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable mask over two words, store data shifter,
// and load merge with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] r0,
  input  logic [31:0] r1,
  output logic [7:0]  mask,
  output logic [63:0] s64,
  output logic [31:0] ldata
);

  logic [7:0]  base;
  logic [63:0] l64;
  logic [31:0] l;

  assign base = (8'd1 << width_of(funct3)) - 8'd1;
  assign mask = base << off;
  assign s64  = {32'b0, wdata} << {off, 3'b000};
  assign l64  = {r1, r0} >> {off, 3'b000};
  assign l    = l64[31:0];

  always_comb begin
    ldata = l;
    case (funct3)
      LB:      ldata = {{24{l[7]}}, l[7:0]};
      LH:      ldata = {{16{l[15]}}, l[15:0]};
      LBU:     ldata = {24'b0, l[7:0]};
      LHU:     ldata = {16'b0, l[15:0]};
      default: ldata = l;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Multi-cycle RV32I load/store unit: one or two byte-enabled bus beats per access,
// core stalled until DONE; 2 stall cycles aligned, 3 split, plus bus wait states.
module riscv_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              Err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wd_q;
  logic [31:0]       r0_q;
  logic              st_q;
  logic [WCNT_W-1:0] wcnt;

  logic              req;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_f3;
  logic [31:0]       sel_wd;
  logic [31:0]       ld_r0;
  logic [31:0]       ld_r1;
  logic [7:0]        mask;
  logic [63:0]       s64;
  logic [31:0]       ldata;

  assign req   = MemRead | MemWrite;
  assign Stall = Reset & req & (state != DONE);

  // Beat 0 lanes are computed from the live request so bus outputs can be registered on accept.
  assign sel_addr = (state == IDLE) ? Addr      : addr_q;
  assign sel_f3   = (state == IDLE) ? Funct3    : f3_q;
  assign sel_wd   = (state == IDLE) ? WriteData : wd_q;
  assign ld_r0    = (state == BEAT1) ? r0_q      : bus_rdata;
  assign ld_r1    = (state == BEAT1) ? bus_rdata : 32'b0;

  lsu_align u_align (
    .off    (sel_addr[1:0]),
    .funct3 (sel_f3),
    .wdata  (sel_wd),
    .r0     (ld_r0),
    .r1     (ld_r1),
    .mask   (mask),
    .s64    (s64),
    .ldata  (ldata)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      wd_q      <= '0;
      r0_q      <= '0;
      st_q      <= 1'b0;
      wcnt      <= '0;
      ReadData  <= '0;
      Err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          Err <= 1'b0;
          if (req) begin
            addr_q <= Addr;
            f3_q   <= Funct3;
            wd_q   <= WriteData;
            st_q   <= MemWrite;
            wcnt   <= '0;
            if (funct3_legal(Funct3, MemWrite)) begin
              state     <= BEAT0;
              bus_req   <= 1'b1;
              bus_we    <= MemWrite;
              bus_addr  <= Addr[ADDR_W-1:2];
              bus_be    <= mask[3:0];
              bus_wdata <= s64[31:0];
            end else begin
              state    <= DONE;
              Err      <= 1'b1;
              ReadData <= '0;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (bus_ack) begin
            wcnt <= '0;
            r0_q <= bus_rdata;
            if (state == BEAT0 && mask[7:4] != 4'b0) begin
              state     <= BEAT1;
              bus_addr  <= addr_q[ADDR_W-1:2] + 1'b1;
              bus_be    <= mask[7:4];
              bus_wdata <= s64[63:32];
            end else begin
              state    <= DONE;
              bus_req  <= 1'b0;
              ReadData <= st_q ? 32'b0 : ldata;
            end
          end else if (wcnt == WCNT_W'(MAX_WAIT - 1)) begin
            state    <= DONE;
            bus_req  <= 1'b0;
            Err      <= 1'b1;
            ReadData <= '0;
            wcnt     <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu with a cycle-stepped bus responder.
module tb_riscv_lsu;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Err;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int vectors = 0;
  int miscompares = 0;

  logic [29:0] o_addr [2];
  logic [3:0]  o_be [2];
  logic [31:0] o_wdata [2];
  logic        o_we [2];
  int          o_stall, o_reqcyc, o_beats;
  logic        o_err, o_done;
  logic [31:0] o_rdata;

  riscv_lsu #(.ADDR_W(32), .MAX_WAIT(255)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Err       (Err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 CLK = ~CLK;

  // Holds the request until Stall drops (DONE); acks beat n after wN wait cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int w0, input logic [31:0] d0,
                            input int w1, input logic [31:0] d1);
    int waitc;
    int w;
    o_stall = 0; o_reqcyc = 0; o_beats = 0; o_done = 1'b0;
    o_err = 1'b0; o_rdata = '0; waitc = 0;
    for (int i = 0; i < 2; i++) begin
      o_addr[i] = '0; o_be[i] = '0; o_wdata[i] = '0; o_we[i] = 1'b0;
    end
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = wd; bus_ack = 1'b0;
    for (int c = 0; c < 600 && !o_done; c++) begin
      #4;
      if (Stall) o_stall++;
      else begin
        o_done = 1'b1;
        o_err = Err;
        o_rdata = ReadData;
      end
      if (bus_req && o_beats < 2) begin
        o_reqcyc++;
        if (waitc == 0) begin
          o_addr[o_beats] = bus_addr;
          o_be[o_beats] = bus_be;
          o_wdata[o_beats] = bus_wdata;
          o_we[o_beats] = bus_we;
        end
        w = (o_beats == 0) ? w0 : w1;
        if (waitc == w) begin
          bus_ack = 1'b1;
          bus_rdata = (o_beats == 0) ? d0 : d1;
          o_beats++;
          waitc = 0;
        end else begin
          bus_ack = 1'b0;
          waitc++;
        end
      end else begin
        bus_ack = 1'b0;
      end
      @(posedge CLK); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
    if (!o_done) begin
      vectors++;
      miscompares++;
      $display("FAIL access_complete: DONE not reached within 600 cycles, addr=%h", a);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h100;
    WriteData = 32'hFFFF_FFFF; bus_rdata = '0; bus_ack = 1'b1;
    #12;
    vectors++;
    if ({ReadData, Err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rd=%h err=%b req=%b we=%b addr=%h be=%b wd=%h, want all 0",
               ReadData, Err, bus_req, bus_we, bus_addr, bus_be, bus_wdata);
    end
    vectors++;
    if (Stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b want 0", Stall);
    end
    MemRead = 1'b0; bus_ack = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_store_word();
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 32'h0, 0, 32'h0);
    vectors++;
    if (o_addr[0] !== 30'h40 || o_be[0] !== 4'b1111 || o_we[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_beat: got addr=%h be=%b we=%b want 40 1111 1", o_addr[0], o_be[0], o_we[0]);
    end
    vectors++;
    if (o_wdata[0] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL sw_wdata: got %h want deadbeef", o_wdata[0]);
    end
    vectors++;
    if (o_stall !== 3 || o_err !== 1'b0 || o_beats !== 1) begin
      miscompares++;
      $display("FAIL sw_timing: got stall=%0d err=%b beats=%0d want 3 0 1", o_stall, o_err, o_beats);
    end
  endtask

  task automatic test_load_byte();
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FF7F, 0, 32'h0);
    vectors++;
    if (o_rdata !== 32'hFFFF_FF80 || o_stall !== 2 || o_be[0] !== 4'b1000) begin
      miscompares++;
      $display("FAIL lb: got rd=%h stall=%0d be=%b want ffffff80 2 1000", o_rdata, o_stall, o_be[0]);
    end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_FF7F, 0, 32'h0);
    vectors++;
    if (o_rdata !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL lbu: got %h want 00000080", o_rdata);
    end
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'hBEEF_0000, 0, 32'h0);
    vectors++;
    if (o_rdata !== 32'hFFFF_BEEF || o_be[0] !== 4'b1100) begin
      miscompares++;
      $display("FAIL lh: got rd=%h be=%b want ffffbeef 1100", o_rdata, o_be[0]);
    end
    run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'hBEEF_0000, 0, 32'h0);
    vectors++;
    if (o_rdata !== 32'h0000_BEEF || o_stall !== 4) begin
      miscompares++;
      $display("FAIL lhu: got rd=%h stall=%0d want 0000beef 4", o_rdata, o_stall);
    end
  endtask

  task automatic test_split_load();
    run_access(1'b1, 1'b0, 3'b010, 32'h1FE, 32'h0, 0, 32'hAABB_CCDD, 0, 32'h1122_3344);
    vectors++;
    if (o_addr[0] !== 30'h7F || o_be[0] !== 4'b1100 || o_addr[1] !== 30'h80 || o_be[1] !== 4'b0011) begin
      miscompares++;
      $display("FAIL lw_split_beats: got %h/%b %h/%b want 7f/1100 80/0011",
               o_addr[0], o_be[0], o_addr[1], o_be[1]);
    end
    vectors++;
    if (o_rdata !== 32'h3344_AABB || o_stall !== 3 || o_beats !== 2) begin
      miscompares++;
      $display("FAIL lw_split_data: got rd=%h stall=%0d beats=%0d want 3344aabb 3 2",
               o_rdata, o_stall, o_beats);
    end
  endtask

  task automatic test_split_store_wrap();
    run_access(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_1234, 0, 32'h0, 1, 32'h0);
    vectors++;
    if (o_addr[0] !== 30'h3FFF_FFFF || o_be[0] !== 4'b1000 || o_wdata[0][31:24] !== 8'h34) begin
      miscompares++;
      $display("FAIL sh_wrap_beat0: got %h/%b/%h want 3fffffff/1000/34..",
               o_addr[0], o_be[0], o_wdata[0]);
    end
    vectors++;
    if (o_addr[1] !== 30'h0 || o_be[1] !== 4'b0001 || o_wdata[1][7:0] !== 8'h12 || o_we[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL sh_wrap_beat1: got %h/%b/%h/%b want 0/0001/..12/1",
               o_addr[1], o_be[1], o_wdata[1], o_we[1]);
    end
    vectors++;
    if (o_stall !== 4 || o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sh_wrap_timing: got stall=%0d err=%b want 4 0", o_stall, o_err);
    end
  endtask

  task automatic test_read_write_both();
    run_access(1'b1, 1'b1, 3'b000, 32'h101, 32'h1234_56AB, 0, 32'h0, 0, 32'h0);
    vectors++;
    if (o_we[0] !== 1'b1 || o_be[0] !== 4'b0010 || o_wdata[0] !== 32'h3456_AB00) begin
      miscompares++;
      $display("FAIL sb_both: got we=%b be=%b wd=%h want 1 0010 3456ab00", o_we[0], o_be[0], o_wdata[0]);
    end
  endtask

  task automatic test_illegal();
    run_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h5555_5555, 0, 32'h0);
    vectors++;
    if (o_reqcyc !== 0 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_stall !== 1) begin
      miscompares++;
      $display("FAIL illegal_load: got req=%0d err=%b rd=%h stall=%0d want 0 1 0 1",
               o_reqcyc, o_err, o_rdata, o_stall);
    end
    run_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0);
    vectors++;
    if (o_reqcyc !== 0 || o_err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_store: got req=%0d err=%b want 0 1", o_reqcyc, o_err);
    end
    #4;
    vectors++;
    if (Err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: got %b after DONE want 0", Err);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1000, 32'h0, 1000, 32'h0);
    vectors++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_reqcyc !== 255 || o_beats !== 0) begin
      miscompares++;
      $display("FAIL timeout: got err=%b rd=%h reqcyc=%0d beats=%0d want 1 0 255 0",
               o_err, o_rdata, o_reqcyc, o_beats);
    end
  endtask

  task automatic test_reset_midbeat();
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h1FE; bus_ack = 1'b0;
    @(posedge CLK); #1;
    bus_ack = 1'b1; bus_rdata = 32'hAABB_CCDD;
    @(posedge CLK); #1;
    bus_ack = 1'b0;
    vectors++;
    if (bus_req !== 1'b1 || bus_be !== 4'b0011 || bus_addr !== 30'h80) begin
      miscompares++;
      $display("FAIL midbeat_setup: got req=%b be=%b addr=%h want 1 0011 80", bus_req, bus_be, bus_addr);
    end
    Reset = 1'b0;
    #1;
    vectors++;
    if (bus_req !== 1'b0 || Stall !== 1'b0 || bus_be !== 4'b0) begin
      miscompares++;
      $display("FAIL midbeat_reset: got req=%b stall=%b be=%b want 0 0 0", bus_req, Stall, bus_be);
    end
    MemRead = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (bus_req !== 1'b0 || Err !== 1'b0) begin
      miscompares++;
      $display("FAIL midbeat_noretry: got req=%b err=%b want 0 0", bus_req, Err);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h1234_5678, 0, 32'h0);
    vectors++;
    if (o_rdata !== 32'h1234_5678 || o_stall !== 2 || o_beats !== 1 || o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midbeat_recover: got rd=%h stall=%0d beats=%0d err=%b want 12345678 2 1 0",
               o_rdata, o_stall, o_beats, o_err);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_split_load();
    test_split_store_wrap();
    test_read_write_both();
    test_illegal();
    test_timeout();
    test_reset_midbeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
